// File: rtl/hit_pkg.sv
// Shared types and constants for the pad hit event queue.
// Event layout and drop counter limit.
package hit_pkg;

  localparam int NUM_PADS = 4;
  localparam int TS_WIDTH = 24;
  localparam int DROP_MAX = 255;

  typedef struct packed {
    logic [NUM_PADS-1:0] mask;
    logic [TS_WIDTH-1:0] tstamp;
  } hit_event_t;

endpackage

// File: rtl/hit_event_queue_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head word.
// Head holds its last value while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    rnext;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign rnext = rptr + PW'(1);

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (do_wr)
        wptr <= wptr + PW'(1);
      if (do_rd)
        rptr <= rnext;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Next head comes from memory unless the popped entry was the last one
      if (do_rd) begin
        if (count > CW'(1))
          dout <= mem[rnext];
        else if (do_wr)
          dout <= din;
      end else if (do_wr && empty) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/hit_event_queue.sv
// Timestamps merged pad hits against a tick counter
// and queues them for a slower consumer.
module hit_event_queue
  import hit_pkg::*;
#(
  parameter int NUM_PADS    = hit_pkg::NUM_PADS,
  parameter int TS_WIDTH    = hit_pkg::TS_WIDTH,
  parameter int CLK_FREQ    = 48000000,
  parameter int TICK_CYCLES = CLK_FREQ / 1000,
  parameter int DEPTH       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_PADS-1:0]      hit_pulse,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic                     evt_valid,
  output logic [NUM_PADS-1:0]      evt_mask,
  output logic [TS_WIDTH-1:0]      evt_time,
  output logic [TS_WIDTH-1:0]      now_time,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int PSW = $clog2(TICK_CYCLES);
  localparam int EW  = NUM_PADS + TS_WIDTH;

  logic [PSW-1:0] prescaler;
  logic           wr;
  logic           drop;
  logic           full;
  logic           empty;
  logic [EW-1:0]  head;

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      now_time  <= '0;
    end else if (prescaler == PSW'(TICK_CYCLES - 1)) begin
      prescaler <= '0;
      now_time  <= now_time + TS_WIDTH'(1);
    end else begin
      prescaler <= prescaler + PSW'(1);
    end
  end

  assign wr   = |hit_pulse;
  // Full implies non-empty, so a same-cycle pop always frees a slot
  assign drop = wr && full && !rd_en;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (wr),
    .din   ({hit_pulse, now_time}),
    .rd_en (rd_en),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fill_level)
  );

  assign evt_valid = !empty;
  assign {evt_mask, evt_time} = head;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)
        drop_count <= 8'd1;
      else if (drop_count != 8'(DROP_MAX))
        drop_count <= drop_count + 8'd1;
    end else if (clr_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_hit_event_queue.sv
// Directed bench for hit_event_queue.
// Main DUT uses 24-bit time; second DUT uses 4-bit time for wrap.
module tb_hit_event_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] hit_pulse;
  logic       rd_en;
  logic       clr_ovf;
  logic       evt_valid;
  logic [3:0] evt_mask;
  logic [23:0] evt_time;
  logic [23:0] now_time;
  logic [2:0] fill_level;
  logic       overflow;
  logic [7:0] drop_count;

  logic       reset6;
  logic [3:0] hit6;
  logic       rd6;
  logic       clr6;
  logic       valid6;
  logic [3:0] mask6;
  logic [3:0] time6;
  logic [3:0] now6;
  logic [2:0] fill6;
  logic       ovf6;
  logic [7:0] drop6;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hit_event_queue #(
    .NUM_PADS(4), .TS_WIDTH(24), .CLK_FREQ(4000),
    .TICK_CYCLES(4), .DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .hit_pulse(hit_pulse),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .evt_valid(evt_valid),
    .evt_mask(evt_mask), .evt_time(evt_time), .now_time(now_time),
    .fill_level(fill_level), .overflow(overflow),
    .drop_count(drop_count)
  );

  hit_event_queue #(
    .NUM_PADS(4), .TS_WIDTH(4), .CLK_FREQ(4000),
    .TICK_CYCLES(4), .DEPTH(4)
  ) dut6 (
    .clk(clk), .reset(reset6), .hit_pulse(hit6),
    .rd_en(rd6), .clr_ovf(clr6), .evt_valid(valid6),
    .evt_mask(mask6), .evt_time(time6), .now_time(now6),
    .fill_level(fill6), .overflow(ovf6), .drop_count(drop6)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hit_pulse = '0;
    rd_en = 1'b0;
    clr_ovf = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({evt_valid, evt_mask, evt_time, fill_level, overflow, drop_count, now_time}
        !== '0) begin
      failures++;
      $display("FAIL reset_state v=%0b m=%0h t=%0d f=%0d o=%0b d=%0d n=%0d exp all 0",
               evt_valid, evt_mask, evt_time, fill_level, overflow, drop_count, now_time);
    end
    step(40);
    checks++;
    if (now_time !== 24'd10) begin
      failures++;
      $display("FAIL idle_now got=%0d exp=10", now_time);
    end
    checks++;
    if (evt_valid !== 1'b0 || fill_level !== 3'd0) begin
      failures++;
      $display("FAIL idle_empty v=%0b f=%0d exp v=0 f=0", evt_valid, fill_level);
    end
  endtask

  task automatic test_single_hit();
    do_reset();
    step(9);
    hit_pulse = 4'b0001;
    step(1);
    hit_pulse = '0;
    checks++;
    if (evt_valid !== 1'b1 || evt_mask !== 4'b0001 ||
        evt_time !== 24'd2 || fill_level !== 3'd1) begin
      failures++;
      $display("FAIL single_hit v=%0b m=%0b t=%0d f=%0d exp v=1 m=0001 t=2 f=1",
               evt_valid, evt_mask, evt_time, fill_level);
    end
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    checks++;
    if (evt_valid !== 1'b0 || fill_level !== 3'd0) begin
      failures++;
      $display("FAIL single_pop v=%0b f=%0d exp v=0 f=0", evt_valid, fill_level);
    end
  endtask

  task automatic test_merge();
    do_reset();
    hit_pulse = 4'b0101;
    step(1);
    hit_pulse = '0;
    step(2);
    checks++;
    if (fill_level !== 3'd1 || evt_mask !== 4'b0101 || evt_valid !== 1'b1) begin
      failures++;
      $display("FAIL merge f=%0d m=%0b v=%0b exp f=1 m=0101 v=1",
               fill_level, evt_mask, evt_valid);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] masks [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      hit_pulse = masks[i];
      step(1);
      hit_pulse = '0;
      step(3);
    end
    checks++;
    if (fill_level !== 3'd4 || overflow !== 1'b1 || drop_count !== 8'd2) begin
      failures++;
      $display("FAIL ovf_state f=%0d o=%0b d=%0d exp f=4 o=1 d=2",
               fill_level, overflow, drop_count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_mask !== masks[i] || evt_time !== 24'(i)) begin
        failures++;
        $display("FAIL ovf_pop%0d v=%0b m=%0h t=%0d exp v=1 m=%0h t=%0d",
                 i, evt_valid, evt_mask, evt_time, masks[i], i);
      end
      rd_en = 1'b1;
      step(1);
      rd_en = 1'b0;
    end
    checks++;
    if (evt_valid !== 1'b0 || fill_level !== 3'd0) begin
      failures++;
      $display("FAIL ovf_drained v=%0b f=%0d exp v=0 f=0", evt_valid, fill_level);
    end
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      failures++;
      $display("FAIL ovf_clear o=%0b d=%0d exp o=0 d=0", overflow, drop_count);
    end
  endtask

  task automatic test_full_pop_write();
    logic [3:0] exp_m [3] = '{4'h2, 4'h4, 4'h8};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      hit_pulse = 4'(1 << i);
      step(1);
    end
    hit_pulse = 4'b0010;
    rd_en = 1'b1;
    step(1);
    hit_pulse = '0;
    rd_en = 1'b0;
    checks++;
    if (fill_level !== 3'd4 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      failures++;
      $display("FAIL full_rw f=%0d o=%0b d=%0d exp f=4 o=0 d=0",
               fill_level, overflow, drop_count);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (evt_mask !== exp_m[i] || evt_time !== 24'd0) begin
        failures++;
        $display("FAIL full_rw_pop%0d m=%0h t=%0d exp m=%0h t=0",
                 i, evt_mask, evt_time, exp_m[i]);
      end
      rd_en = 1'b1;
      step(1);
      rd_en = 1'b0;
    end
    checks++;
    if (evt_mask !== 4'b0010 || evt_time !== 24'd1 || fill_level !== 3'd1) begin
      failures++;
      $display("FAIL full_rw_tail m=%0b t=%0d f=%0d exp m=0010 t=1 f=1",
               evt_mask, evt_time, fill_level);
    end
    hit_pulse = 4'b0001;
    step(3);
    step(1);
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd1 || fill_level !== 3'd4) begin
      failures++;
      $display("FAIL first_drop o=%0b d=%0d f=%0d exp o=1 d=1 f=4",
               overflow, drop_count, fill_level);
    end
    clr_ovf = 1'b1;
    step(1);
    hit_pulse = '0;
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd1) begin
      failures++;
      $display("FAIL drop_wins o=%0b d=%0d exp o=1 d=1", overflow, drop_count);
    end
  endtask

  task automatic test_wrap_reset();
    reset6 = 1'b1;
    hit6 = '0;
    rd6 = 1'b0;
    clr6 = 1'b0;
    step(1);
    reset6 = 1'b0;
    step(60);
    checks++;
    if (now6 !== 4'd15) begin
      failures++;
      $display("FAIL wrap_pre got=%0d exp=15", now6);
    end
    step(4);
    checks++;
    if (now6 !== 4'd0) begin
      failures++;
      $display("FAIL wrap_post got=%0d exp=0", now6);
    end
    hit6 = 4'b0100;
    step(2);
    hit6 = '0;
    checks++;
    if (fill6 !== 3'd2 || valid6 !== 1'b1 || mask6 !== 4'b0100) begin
      failures++;
      $display("FAIL queued2 f=%0d v=%0b m=%0b exp f=2 v=1 m=0100",
               fill6, valid6, mask6);
    end
    reset6 = 1'b1;
    hit6 = 4'b1000;
    step(1);
    reset6 = 1'b0;
    hit6 = '0;
    checks++;
    if (fill6 !== 3'd0 || valid6 !== 1'b0 || now6 !== 4'd0 ||
        mask6 !== 4'd0 || time6 !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset f=%0d v=%0b n=%0d m=%0h t=%0d exp all 0",
               fill6, valid6, now6, mask6, time6);
    end
    rd6 = 1'b1;
    step(1);
    rd6 = 1'b0;
    checks++;
    if (fill6 !== 3'd0 || valid6 !== 1'b0 || mask6 !== 4'd0 ||
        ovf6 !== 1'b0 || drop6 !== 8'd0) begin
      failures++;
      $display("FAIL empty_read f=%0d v=%0b m=%0h o=%0b d=%0d exp all 0",
               fill6, valid6, mask6, ovf6, drop6);
    end
  endtask

  initial begin
    reset = 1'b1;
    hit_pulse = '0;
    rd_en = 1'b0;
    clr_ovf = 1'b0;
    reset6 = 1'b1;
    hit6 = '0;
    rd6 = 1'b0;
    clr6 = 1'b0;
    step(2);
    test_reset();
    test_single_hit();
    test_merge();
    test_overflow();
    test_full_pop_write();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
